// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver folding E0/F0 prefixes into key events.
// Optional typematic-repeat suppression: define PS2_REPEAT_FILTER_EN.
module ps2_kbd_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       key_strobe,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_f, dat_f, fall;
  logic [CW-1:0] clk_cnt, dat_cnt;

  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          parity;
  logic [WW-1:0] wdog;
  logic          byte_rdy;
  logic          pend_ext, pend_rel;
  logic          emit;

  // Synchroniser plus saturating filter; fall pulses in the same cycle clk_f drops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_f    <= 1'b1;
      dat_f    <= 1'b1;
      clk_cnt  <= '0;
      dat_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      fall     <= 1'b0;
      if (clk_sync[1] != clk_f) begin
        if (clk_cnt == CW'(FILTER_LEN - 1)) begin
          clk_f   <= clk_sync[1];
          clk_cnt <= '0;
          fall    <= clk_f;
        end else begin
          clk_cnt <= clk_cnt + CW'(1);
        end
      end else begin
        clk_cnt <= '0;
      end
      if (dat_sync[1] != dat_f) begin
        if (dat_cnt == CW'(FILTER_LEN - 1)) begin
          dat_f   <= dat_sync[1];
          dat_cnt <= '0;
        end else begin
          dat_cnt <= dat_cnt + CW'(1);
        end
      end else begin
        dat_cnt <= '0;
      end
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic       last_valid, last_ext;
  logic [7:0] last_code;
  logic       last_match;

  assign last_match = last_valid && (last_ext == pend_ext) && (last_code == shreg);
  assign emit       = pend_rel || !last_match;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_valid <= 1'b0;
      last_ext   <= 1'b0;
      last_code  <= '0;
    end else if (byte_rdy && shreg != 8'hE0 && shreg != 8'hF0) begin
      if (!pend_rel && !last_match) begin
        last_valid <= 1'b1;
        last_ext   <= pend_ext;
        last_code  <= shreg;
      end else if (pend_rel && last_match) begin
        last_valid <= 1'b0;
      end
    end
  end
`else
  assign emit = 1'b1;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bitcnt       <= '0;
      shreg        <= '0;
      parity       <= 1'b0;
      wdog         <= '0;
      byte_rdy     <= 1'b0;
      pend_ext     <= 1'b0;
      pend_rel     <= 1'b0;
      key_strobe   <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
      byte_rdy   <= 1'b0;

      // shreg stays put in IDLE, so it still holds the accepted byte here.
      if (byte_rdy) begin
        if (shreg == 8'hE0) begin
          pend_ext <= 1'b1;
        end else if (shreg == 8'hF0) begin
          pend_rel <= 1'b1;
        end else begin
          pend_ext <= 1'b0;
          pend_rel <= 1'b0;
          if (emit) begin
            key_strobe   <= 1'b1;
            key_code     <= shreg;
            key_extended <= pend_ext;
            key_released <= pend_rel;
          end
        end
      end

      if (state != IDLE && wdog == WW'(TIMEOUT)) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        wdog      <= '0;
        pend_ext  <= 1'b0;
        pend_rel  <= 1'b0;
      end else begin
        if (state == IDLE || fall) wdog <= '0;
        else                       wdog <= wdog + WW'(1);
        if (fall) begin
          case (state)
            IDLE: begin
              if (!dat_f) begin
                state  <= DATA;
                bitcnt <= '0;
                parity <= 1'b1;
              end else begin
                frame_err <= 1'b1;
                pend_ext  <= 1'b0;
                pend_rel  <= 1'b0;
              end
            end
            DATA: begin
              shreg  <= {dat_f, shreg[7:1]};
              parity <= parity ^ dat_f;
              bitcnt <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
              parity <= parity ^ dat_f;
              state  <= STOP;
            end
            STOP: begin
              if (dat_f && !parity) begin
                byte_rdy <= 1'b1;
              end else begin
                frame_err <= 1'b1;
                pend_ext  <= 1'b0;
                pend_rel  <= 1'b0;
              end
              state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- PS/2 keyboard receiver sitting directly upstream of the machine core's keyboard input.
- Samples the raw PS/2 clock and data lines and deserialises 11-bit device-to-host frames.
- Folds E0/F0 prefix bytes into flags and emits one key-event strobe per complete make/break code.
- The keyboard-matrix logic consumes the event stream. The block runs on clk_sys.

Parameters:
- FILTER_LEN, 8: consecutive identical samples needed before a filtered PS/2 line changes state (range 2..32).
- TIMEOUT, 65535: clock cycles without a falling PS/2 clock edge, while mid-frame, before the frame is aborted.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- ps2_clk  input  1  raw PS/2 clock line, asynchronous.
- ps2_dat  input  1  raw PS/2 data line, asynchronous.
- key_strobe  output  1  one-cycle pulse: key event valid.
- key_code  output  8  scan code of the event; held until the next event.
- key_extended  output  1  event was preceded by E0; held with key_code.
- key_released  output  1  event was preceded by F0 (break); held with key_code.
- frame_err  output  1  one-cycle pulse on parity, start/stop or timeout error.
- busy  output  1  high while a frame is being received (state != IDLE).

Behaviour:
- Clock and reset:
  - One clock domain; reset is asynchronous and active-low.
  - Reset values: all outputs 0, state IDLE, prefix flags 0, filtered lines 1, filter counters 0.
- Input conditioning:
  - Each PS/2 line passes through a 2-FF synchroniser, then a saturating filter.
  - A filtered line toggles only after FILTER_LEN consecutive synchronised samples differ from its current value.
  - A falling edge is filtered clk going from 1 to 0; it is registered as a one-cycle fall pulse.
  - The data bit is taken from filtered dat in the same cycle as the fall pulse.
- State machine:
  - IDLE: on fall with dat=0, go to DATA with bitcnt=0 and parity accumulator=1. On fall with dat=1 (bad start), pulse frame_err and stay in IDLE.
  - DATA: on each fall, shift dat into shreg[7] (right shift, so LSB is received first) and XOR it into parity; bitcnt+1. After the 8th bit, go to PARITY.
  - PARITY: on fall, XOR dat into the accumulator, then go to STOP. The accumulator must be 0 at STOP for odd parity to hold.
  - STOP: on fall, if dat=1 and parity is OK, accept the byte; otherwise pulse frame_err. Either way, go to IDLE.
- Watchdog:
  - Any state other than IDLE runs a watchdog counter, reset on every fall.
  - When the counter reaches TIMEOUT: pulse frame_err, go to IDLE, clear the prefix flags.
- Byte acceptance (one cycle after the STOP fall):
  - E0: set pend_ext; no strobe.
  - F0: set pend_rel; no strobe.
  - Any other byte: key_code = byte, key_extended = pend_ext, key_released = pend_rel, key_strobe = 1 for exactly one cycle, then clear both pend flags.
- Boundary conditions:
  - A frame error clears pend_ext and pend_rel.
  - E0 E0 keeps pend_ext=1. F0 followed by E0 sets both flags.
  - A fall arriving in the same cycle the watchdog fires is ignored.
- Latency: key_strobe asserts 2 cycles after the filtered falling edge of the stop bit.
- key_code, key_extended and key_released change only together with key_strobe.

Optional Feature:
- Macro: PS2_REPEAT_FILTER_EN.
- With the macro defined:
  - The block keeps last_make = {valid, ext, code}.
  - A make event whose ext and code equal last_make while valid=1 is a typematic repeat. It produces no strobe, and the prefix flags are cleared.
  - A make event that is not a repeat loads last_make.
  - A break event matching last_make clears valid.
  - Reset clears valid.
- Without the macro: every make event strobes, including typematic repeats. No last_make register exists.

Test Plan:
- Frame 0x1C (start 0, data LSB first, parity 0, stop 1) at a 12.5 kHz PS/2 clock, FILTER_LEN=8 -> single key_strobe with key_code=0x1C, extended=0, released=0; frame_err stays 0.
- Frames F0, 1C -> one strobe, code 0x1C, released=1. Then frames E0, F0, 75 -> one strobe, code 0x75, extended=1, released=1.
- Frame 0x1C with the parity bit flipped to 1 -> frame_err pulse, no strobe. The next valid 0x29 frame strobes code 0x29 with released=0.
- E0 frame, then clock stops after 4 data bits of the next frame for TIMEOUT+10 cycles -> frame_err pulse, busy=0. A following 0x74 frame strobes with extended=0.
- 3-cycle low glitch on ps2_clk while IDLE with FILTER_LEN=8 -> no state change, busy stays 0. Reset asserted mid-frame -> all outputs 0 immediately; next complete frame decodes correctly.
- With PS2_REPEAT_FILTER_EN: frames 1C, 1C, 1C, F0, 1C, 1C -> strobes are make 1C, break 1C, make 1C (3 total). Without the macro -> 5 strobes.
